fdiv_round_pack: RTL and testbench

Pipelined back end of the single-precision divider. It consumes the raw mantissa quotient, sign and pre-normalised biased exponent from the divider core, then normalises, rounds to nearest-even, detects overflow and underflow, and packs an IEEE-754 binary32 word. It sits directly downstream of the mantissa-divide/exponent-subtract stage and replaces its combinational shift-normalise chain with a registered, back-pressurable two-stage pipeline.

---
 rtl/fdiv_pkg.sv | 21 ++
 rtl/fdiv_rne24.sv | 23 ++
 rtl/fdiv_round_pack.sv | 133 +++++++++++++
 tb/tb_fdiv_round_pack.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fdiv_pkg.sv
// Shared encodings and field widths for the binary32 divider back end.
package fdiv_pkg;

  localparam int EXP_W  = 10;
  localparam int QUO_W  = 26;
  localparam int MANT_W = 24;
  localparam int FRAC_W = 23;

  localparam logic signed [EXP_W-1:0] BIAS    = 10'sd127;
  localparam logic signed [EXP_W-1:0] EXP_MAX = 10'sd255;
  localparam logic signed [EXP_W-1:0] EXP_MIN = 10'sd0;
  localparam logic [31:0]             QNAN    = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    CLS_NORMAL = 2'b00,
    CLS_ZERO   = 2'b01,
    CLS_INF    = 2'b10,
    CLS_NAN    = 2'b11
  } cls_e;

endpackage

// File: rtl/fdiv_rne24.sv
// Combinational round-to-nearest-even incrementer for a 24-bit mantissa.
module fdiv_rne24
  import fdiv_pkg::*;
(
  input  logic [MANT_W-1:0] mant_i,
  input  logic              guard_i,
  input  logic              sticky_i,
  output logic [MANT_W-1:0] mant_o,
  output logic              carry_o,
  output logic              inexact_o
);

  logic              roundUp;
  logic [MANT_W:0]   sum;

  assign roundUp   = guard_i & (sticky_i | mant_i[0]);
  assign sum       = {1'b0, mant_i} + {{MANT_W{1'b0}}, roundUp};
  assign carry_o   = sum[MANT_W];
  // An overflowing increment renormalises to 1.0 with the exponent bumped by the caller.
  assign mant_o    = sum[MANT_W] ? {1'b1, {(MANT_W-1){1'b0}}} : sum[MANT_W-1:0];
  assign inexact_o = guard_i | sticky_i;

endmodule

// File: rtl/fdiv_round_pack.sv
// Two-stage back-pressurable normalise / round / pack pipeline for the binary32 divider.
module fdiv_round_pack
  import fdiv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              in_sign_i,
  input  logic [EXP_W-1:0]  in_exp_i,
  input  logic [QUO_W-1:0]  in_quo_i,
  input  logic              in_sticky_i,
  input  logic [1:0]        in_class_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       out_result_o,
  output logic [2:0]        out_flags_o
);

  logic                     s1Valid_q, s2Valid_q;
  logic                     s1Adv, s2Adv;
  logic [MANT_W-1:0]        s1Mant_q, s1Mant_d;
  logic signed [EXP_W-1:0]  s1Exp_q, s1Exp_d;
  logic                     s1Guard_q, s1Guard_d;
  logic                     s1Sticky_q, s1Sticky_d;
  logic                     s1Sign_q;
  cls_e                     s1Cls_q;
  logic [31:0]              result_q, result_d;
  logic [2:0]               flags_q, flags_d;
  logic [MANT_W-1:0]        rndMant;
  logic                     rndCarry, rndInexact;
  logic signed [EXP_W-1:0]  finalExp;
  logic                     unusedHidden;

  assign s2Adv      = !s2Valid_q | out_ready_i;
  assign s1Adv      = !s1Valid_q | s2Adv;
  assign in_ready_o = s1Adv;

  always_comb begin
    s1Mant_d   = in_quo_i[24:1];
    s1Guard_d  = in_quo_i[0];
    s1Sticky_d = in_sticky_i;
    s1Exp_d    = $signed(in_exp_i) - 10'sd1;
    if (in_quo_i[25]) begin
      s1Mant_d   = in_quo_i[25:2];
      s1Guard_d  = in_quo_i[1];
      s1Sticky_d = in_quo_i[0] | in_sticky_i;
      s1Exp_d    = $signed(in_exp_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid_q  <= 1'b0;
      s1Mant_q   <= '0;
      s1Exp_q    <= '0;
      s1Guard_q  <= 1'b0;
      s1Sticky_q <= 1'b0;
      s1Sign_q   <= 1'b0;
      s1Cls_q    <= CLS_NORMAL;
    end else if (s1Adv) begin
      s1Valid_q <= in_valid_i;
      if (in_valid_i) begin
        s1Mant_q   <= s1Mant_d;
        s1Exp_q    <= s1Exp_d;
        s1Guard_q  <= s1Guard_d;
        s1Sticky_q <= s1Sticky_d;
        s1Sign_q   <= in_sign_i;
        s1Cls_q    <= cls_e'(in_class_i);
      end
    end
  end

  fdiv_rne24 u_rne (
    .mant_i    (s1Mant_q),
    .guard_i   (s1Guard_q),
    .sticky_i  (s1Sticky_q),
    .mant_o    (rndMant),
    .carry_o   (rndCarry),
    .inexact_o (rndInexact)
  );

  assign finalExp     = s1Exp_q + $signed({{(EXP_W-1){1'b0}}, rndCarry});
  assign unusedHidden = rndMant[MANT_W-1];

  // Special classes skip rounding entirely; NaN is always the canonical quiet NaN.
  always_comb begin
    result_d = {s1Sign_q, finalExp[7:0], rndMant[FRAC_W-1:0]};
    flags_d  = {2'b00, rndInexact};
    case (s1Cls_q)
      CLS_ZERO: begin
        result_d = {s1Sign_q, 31'b0};
        flags_d  = 3'b000;
      end
      CLS_INF: begin
        result_d = {s1Sign_q, 8'hFF, 23'b0};
        flags_d  = 3'b000;
      end
      CLS_NAN: begin
        result_d = QNAN;
        flags_d  = 3'b000;
      end
      default: begin
        if (finalExp >= EXP_MAX) begin
          result_d = {s1Sign_q, 8'hFF, 23'b0};
          flags_d  = 3'b101;
        end else if (finalExp <= EXP_MIN) begin
          result_d = {s1Sign_q, 31'b0};
          flags_d  = 3'b011;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2Valid_q <= 1'b0;
      result_q  <= '0;
      flags_q   <= '0;
    end else if (s2Adv) begin
      s2Valid_q <= s1Valid_q;
      if (s1Valid_q) begin
        result_q <= result_d;
        flags_q  <= flags_d;
      end
    end
  end

  assign out_valid_o  = s2Valid_q;
  assign out_result_o = result_q;
  assign out_flags_o  = flags_q;

endmodule

// File: tb/tb_fdiv_round_pack.sv
// Directed bench for fdiv_round_pack: rounding, range limits, specials, stalls and reset.
module tb_fdiv_round_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        inValid, inReady, inSign, inSticky;
  logic [9:0]  inExp;
  logic [25:0] inQuo;
  logic [1:0]  inClass;
  logic        outValid, outReady;
  logic [31:0] outResult;
  logic [2:0]  outFlags;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  fdiv_round_pack dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid_i   (inValid),
    .in_ready_o   (inReady),
    .in_sign_i    (inSign),
    .in_exp_i     (inExp),
    .in_quo_i     (inQuo),
    .in_sticky_i  (inSticky),
    .in_class_i   (inClass),
    .out_valid_o  (outValid),
    .out_ready_i  (outReady),
    .out_result_o (outResult),
    .out_flags_o  (outFlags)
  );

  // All driving and sampling happens 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    vectors++;
    assert (obs === expd) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expd);
    end
  endtask

  task automatic present(input logic s, input logic [9:0] e, input logic [25:0] q,
                         input logic st, input logic [1:0] c);
    inValid  = 1'b1;
    inSign   = s;
    inExp    = e;
    inQuo    = q;
    inSticky = st;
    inClass  = c;
  endtask

  // Presents one operand set and returns just after the accepting edge.
  task automatic applyStimulus(input logic s, input logic [9:0] e, input logic [25:0] q,
                               input logic st, input logic [1:0] c);
    int n = 0;
    present(s, e, q, st, c);
    while (!inReady && n < 10) begin
      tick();
      n++;
    end
    if (!inReady) begin
      errors++;
      $display("[TB] FAIL accept_timeout: in_ready stuck at %b, required 1", inReady);
    end
    tick();
    inValid = 1'b0;
  endtask

  // Waits a bounded number of cycles for out_valid, then checks the result.
  task automatic checkOutput(input string tag, input logic [31:0] expRes, input logic [2:0] expFlags);
    int n = 0;
    while (!outValid && n < 5) begin
      tick();
      n++;
    end
    checkVal({tag, "_valid"}, {31'b0, outValid}, 32'd1);
    checkVal({tag, "_res"}, outResult, expRes);
    checkVal({tag, "_flags"}, {29'b0, outFlags}, {29'b0, expFlags});
    tick();
  endtask

  initial begin
    rst      = 1'b1;
    inValid  = 1'b0;
    inSign   = 1'b0;
    inExp    = '0;
    inQuo    = '0;
    inSticky = 1'b0;
    inClass  = 2'b00;
    outReady = 1'b1;
    #12;
    checkVal("rst_valid", {31'b0, outValid}, 32'd0);
    checkVal("rst_result", outResult, 32'h0);
    checkVal("rst_flags", {29'b0, outFlags}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    checkVal("rst_in_ready", {31'b0, inReady}, 32'd1);

    // 6.0/2.0 with explicit latency checks
    applyStimulus(1'b0, 10'd128, 26'h3000000, 1'b0, 2'b00);
    checkVal("lat_early", {31'b0, outValid}, 32'd0);
    tick();
    checkVal("lat_valid", {31'b0, outValid}, 32'd1);
    checkVal("div6_2_res", outResult, 32'h40400000);
    checkVal("div6_2_flags", {29'b0, outFlags}, 32'd0);
    tick();
    checkVal("lat_drop", {31'b0, outValid}, 32'd0);

    applyStimulus(1'b0, 10'd127, 26'h1555555, 1'b1, 2'b00);
    checkOutput("div1_1p5", 32'h3F2AAAAB, 3'b001);
    applyStimulus(1'b0, 10'd127, 26'h3FFFFFF, 1'b1, 2'b00);
    checkOutput("rnd_carry", 32'h40000000, 3'b001);
    applyStimulus(1'b0, 10'd127, 26'h2000002, 1'b0, 2'b00);
    checkOutput("tie_even", 32'h3F800000, 3'b001);
    applyStimulus(1'b0, 10'd127, 26'h2000006, 1'b0, 2'b00);
    checkOutput("tie_odd", 32'h3F800002, 3'b001);
    applyStimulus(1'b1, 10'd255, 26'h2000000, 1'b0, 2'b00);
    checkOutput("ovf", 32'hFF800000, 3'b101);
    applyStimulus(1'b0, 10'd254, 26'h3FFFFFF, 1'b1, 2'b00);
    checkOutput("ovf_carry", 32'h7F800000, 3'b101);
    applyStimulus(1'b0, 10'd0, 26'h1000000, 1'b0, 2'b00);
    checkOutput("unf", 32'h00000000, 3'b011);
    applyStimulus(1'b1, 10'd1, 26'h1000000, 1'b0, 2'b00);
    checkOutput("unf_norm", 32'h80000000, 3'b011);
    applyStimulus(1'b0, 10'd1, 26'h2000000, 1'b0, 2'b00);
    checkOutput("min_norm", 32'h00800000, 3'b000);
    applyStimulus(1'b1, 10'd127, 26'h3FFFFFF, 1'b1, 2'b11);
    checkOutput("nan", 32'h7FC00000, 3'b000);
    applyStimulus(1'b1, 10'd0, 26'h1000000, 1'b1, 2'b10);
    checkOutput("inf", 32'hFF800000, 3'b000);
    applyStimulus(1'b1, 10'd255, 26'h2000000, 1'b0, 2'b01);
    checkOutput("zero", 32'h80000000, 3'b000);

    // Back-pressure: two accepts then stall, then drain at full rate
    outReady = 1'b0;
    present(1'b0, 10'd128, 26'h2000000, 1'b0, 2'b00);
    checkVal("bp_ready0", {31'b0, inReady}, 32'd1);
    tick();
    present(1'b0, 10'd129, 26'h2000000, 1'b0, 2'b00);
    checkVal("bp_ready1", {31'b0, inReady}, 32'd1);
    tick();
    present(1'b0, 10'd130, 26'h2000000, 1'b0, 2'b00);
    checkVal("bp_ready2", {31'b0, inReady}, 32'd0);
    checkVal("bp_hold_valid", {31'b0, outValid}, 32'd1);
    checkVal("bp_hold_res0", outResult, 32'h40000000);
    tick();
    checkVal("bp_ready3", {31'b0, inReady}, 32'd0);
    checkVal("bp_hold_res1", outResult, 32'h40000000);
    outReady = 1'b1;
    #1;
    checkVal("bp_ready_comb", {31'b0, inReady}, 32'd1);
    tick();
    checkVal("bp_out1", outResult, 32'h40800000);
    checkVal("bp_out1_valid", {31'b0, outValid}, 32'd1);
    present(1'b0, 10'd131, 26'h2000000, 1'b0, 2'b00);
    checkVal("bp_ready4", {31'b0, inReady}, 32'd1);
    tick();
    inValid = 1'b0;
    checkVal("bp_out2", outResult, 32'h41000000);
    checkVal("bp_out2_valid", {31'b0, outValid}, 32'd1);
    tick();
    checkVal("bp_out3", outResult, 32'h41800000);
    checkVal("bp_out3_valid", {31'b0, outValid}, 32'd1);
    tick();
    checkVal("bp_drained", {31'b0, outValid}, 32'd0);

    // Reset with two operands in flight
    outReady = 1'b0;
    applyStimulus(1'b0, 10'd128, 26'h3000000, 1'b0, 2'b00);
    applyStimulus(1'b0, 10'd129, 26'h3000000, 1'b0, 2'b00);
    rst = 1'b1;
    #1;
    checkVal("mid_rst_valid", {31'b0, outValid}, 32'd0);
    tick();
    checkVal("mid_rst_result", outResult, 32'h0);
    @(negedge clk);
    rst      = 1'b0;
    outReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkVal("post_rst_quiet", {31'b0, outValid}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
